// File: rtl/mux_21_rr_arbiter_if.sv
// Valid/ready stream bundle used for both requesters and the output stage.
// The master drives valid/data; the slave drives ready.
interface mux_21_rr_arbiter_if #(
  parameter int DATA_W = 8
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/mux_21_rr_arbiter.sv
// Round-robin 2:1 stream mux with bounded bursts per grant.
// The selected beat is registered into a one-entry output stage.
module mux_21_rr_arbiter #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  mux_21_rr_arbiter_if.slave          in0,
  mux_21_rr_arbiter_if.slave          in1,
  mux_21_rr_arbiter_if.master         out,
  output logic                        sel
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic              last_grant;
  logic              last_grant_nx;
  logic [CNT_W-1:0]  beat_cnt;
  logic [CNT_W-1:0]  beat_cnt_nx;
  logic [CNT_W-1:0]  cnt_inc;
  logic              out_valid;
  logic              out_valid_nx;
  logic [DATA_W-1:0] out_data;
  logic [DATA_W-1:0] out_data_nx;

  logic load_en;
  logic keep0;
  logic keep1;
  logic gnt_vld;
  logic gnt_idx;
  logic ready0;
  logic ready1;
  logic xfer0;
  logic xfer1;

  assign load_en = !out_valid || out.ready;

  // The burst limit only bites while the other side is waiting.
  assign keep0 = (state == GRANT0) && in0.valid &&
                 ((beat_cnt < CNT_MAX) || !in1.valid);
  assign keep1 = (state == GRANT1) && in1.valid &&
                 ((beat_cnt < CNT_MAX) || !in0.valid);

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = last_grant;
    if (keep0) begin
      gnt_vld = 1'b1;
      gnt_idx = 1'b0;
    end else if (keep1) begin
      gnt_vld = 1'b1;
      gnt_idx = 1'b1;
    end else if (in0.valid && in1.valid) begin
      gnt_vld = 1'b1;
      gnt_idx = !last_grant;
    end else if (in0.valid) begin
      gnt_vld = 1'b1;
      gnt_idx = 1'b0;
    end else if (in1.valid) begin
      gnt_vld = 1'b1;
      gnt_idx = 1'b1;
    end
  end

  assign ready0 = !rst && load_en && gnt_vld && !gnt_idx;
  assign ready1 = !rst && load_en && gnt_vld && gnt_idx;

  assign in0.ready = ready0;
  assign in1.ready = ready1;
  assign xfer0     = in0.valid && ready0;
  assign xfer1     = in1.valid && ready1;

  assign sel       = gnt_idx;
  assign out.valid = out_valid;
  assign out.data  = out_data;

  assign cnt_inc = (beat_cnt == CNT_MAX) ? beat_cnt
                                         : beat_cnt + CNT_W'(1);

  always_comb begin
    state_nx      = state;
    last_grant_nx = last_grant;
    beat_cnt_nx   = beat_cnt;
    out_valid_nx  = out_valid;
    out_data_nx   = out_data;
    unique case (1'b1)
      xfer0: begin
        out_valid_nx  = 1'b1;
        out_data_nx   = in0.data;
        state_nx      = GRANT0;
        last_grant_nx = 1'b0;
        beat_cnt_nx   = (state == GRANT0) ? cnt_inc : CNT_W'(1);
      end
      xfer1: begin
        out_valid_nx  = 1'b1;
        out_data_nx   = in1.data;
        state_nx      = GRANT1;
        last_grant_nx = 1'b1;
        beat_cnt_nx   = (state == GRANT1) ? cnt_inc : CNT_W'(1);
      end
      (load_en && !xfer0 && !xfer1): begin
        out_valid_nx = 1'b0;
        state_nx     = IDLE;
        beat_cnt_nx  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
      beat_cnt   <= beat_cnt_nx;
      out_valid  <= out_valid_nx;
      out_data   <= out_data_nx;
    end
  end

endmodule
